ft60x_fifo_bridge: RTL and testbench
====================================

// Module: ft60x_fifo_bridge
// PURPOSE
//  Parametrised FT600/FT601 245-synchronous FIFO-mode bridge between the USB chip's bus and the master TX/RX FIFOs.
//  Clocked entirely by usb_clk.
//  Arbitrates fairly between host->FPGA reads and FPGA->host writes.
//  Inserts bus turnaround cycles, bounds burst lengths and forwards byte enables.
//  Sits between the pad layer (active-high presentation of RXF/TXE/WR/RD/OE) and the dual-clock master FIFOs.
// PARAMETERS
//  DATA_W        32    bus width; 16 (FT600) or 32 (FT601); BE_W = DATA_W/8
//  PACKET_SIZE   1024  max words per write burst
//  RX_MAX_BURST  1024  max words per read burst before forced re-arbitration
//  FLUSH_TIMEOUT 4096  usb_clk cycles before a partial TX packet is flushed (FT_TX_FLUSH_EN only)
// PORTS
//  usb_clk            in    1       FT60x clock; sole clock
//  rst                in    1       asynchronous, active-high reset
//  usb_rxf            in    1       1 = chip has data for FPGA
//  usb_txe            in    1       1 = chip can accept data
//  usb_wr             out   1       write strobe
//  usb_rd             out   1       read strobe
//  usb_oe             out   1       chip output enable
//  usb_data           inout DATA_W  data bus
//  usb_be             inout BE_W    byte enables
//  tx_fifo_prog_empty in    1       1 = fewer than threshold words queued
//  tx_fifo_empty      in    1       1 = TX FIFO empty (FWFT FIFO)
//  tx_fifo_data       in    DATA_W  FWFT head word
//  tx_fifo_read       out   1       pop TX FIFO
//  rx_fifo_prog_full  in    1       1 = RX FIFO near full
//  rx_fifo_data       out   DATA_W  registered captured word
//  rx_fifo_be         out   BE_W    registered captured byte enables
//  rx_fifo_write      out   1       push RX FIFO
// BEHAVIOUR
//  Reset: async; state=IDLE; usb_wr/rd/oe, tx_fifo_read, rx_fifo_write = 0; rx_fifo_data/be = 0.
//    Bus is released (Z) immediately, including mid-burst.
//  States (one-hot): IDLE, RD_OE, RD, TURN, WR.
//  Eligibility:
//    rx_ok = usb_rxf & ~rx_fifo_prog_full
//    tx_ok = usb_txe & ~tx_fifo_prog_empty
//  IDLE: if both eligible, serve the direction NOT served last (last_dir flop, reset = WR, so RX wins first).
//    Otherwise serve whichever is eligible; else stay.
//  RD_OE: usb_oe_q=1 for exactly one cycle, bus not driven -> RD.
//  RD: usb_oe_q=1, usb_rd_q=1.
//    Word accepted on each cycle with usb_rd & usb_rxf.
//    Next cycle: rx_fifo_data <= usb_data, rx_fifo_be <= usb_be, rx_fifo_write=1 (1-cycle latency).
//    Exit to TURN when ~usb_rxf, rx_fifo_prog_full, or rd_cnt == RX_MAX_BURST.
//  WR: usb_data = tx_fifo_data, usb_be = all ones, driven only in WR.
//    usb_wr = wr_q & ~tx_fifo_empty; tx_fifo_read = usb_wr & usb_txe (combinational).
//    wr_cnt increments on each tx_fifo_read.
//    Exit to TURN when wr_cnt reaches PACKET_SIZE, ~usb_txe, or tx_fifo_empty.
//  TURN: all strobes 0, bus Z, exactly 1 cycle -> IDLE; last_dir updated.
//  Counters: $clog2(max)+1 bits; cleared on entry to RD_OE/WR; never wrap.
//  usb_oe/usb_rd/wr_q are flops; no strobe is ever asserted in IDLE or TURN.
//  rx_fifo_prog_full asserting mid-burst: at most 2 further words are pushed; the FIFO threshold must leave >= 2 words of slack.
// CONFIGURATION
//  FT_TX_FLUSH_EN defined:
//    flush_timer counts cycles with ~tx_fifo_empty & tx_fifo_prog_empty; cleared on WR entry or when either condition drops.
//    At FLUSH_TIMEOUT, tx_ok is forced to usb_txe; WR drains until tx_fifo_empty (short packet).
//  FT_TX_FLUSH_EN undefined:
//    no timer; residual words below the threshold wait indefinitely; FLUSH_TIMEOUT is ignored.
// STRUCTURE
//  ft60x_defs.vh: state one-hot encodings, DIR_RD/DIR_WR, BE_W derivation, counter-width function.
//  Sub-module ft60x_flush_timer (instantiated only under FT_TX_FLUSH_EN): inputs cond, clr; output expired.
// TESTING
//  1 rxf=1 for 8 words, prog_full=0 -> oe rises 1 cycle before rd; 8 rx_fifo_write pulses carry the words in order.
//  2 tx_prog_empty=0, txe=1, 1500 words queued -> first burst is exactly 1024 words, then TURN, then 476 words.
//  3 Both sides eligible continuously -> bursts alternate RD, WR, RD; exactly 1 TURN cycle between each; bus never driven in RD/RD_OE.
//  4 rx_fifo_prog_full set mid-read after word 5 -> <= 7 words pushed, RD exits to TURN, no push lost or duplicated.
//  5 rst asserted mid-WR (word 300) -> usb_wr, tx_fifo_read = 0 and usb_data Z in the same cycle; state IDLE after release.
//  6 FT_TX_FLUSH_EN, 3 words queued, prog_empty=1 -> after 4096 cycles 3 words sent, then IDLE; without the macro, 0 sent.

Source files
------------

// File: rtl/ft60x_fifo_bridge_pkg.sv
// Shared types and sizing helpers for the FT60x FIFO-mode bridge.
package ft60x_fifo_bridge_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_RD_OE = 5'b00010,
    ST_RD    = 5'b00100,
    ST_TURN  = 5'b01000,
    ST_WR    = 5'b10000
  } state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  // Wide enough to hold max_val itself, so a full burst is representable.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ft60x_fifo_bridge_if.sv
// Strobe/status and master-FIFO signals of the FT60x bridge; master = bridge side.
interface ft60x_fifo_bridge_if
  import ft60x_fifo_bridge_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  localparam int BE_W = be_width(DATA_W);

  logic              usb_rxf;
  logic              usb_txe;
  logic              usb_wr;
  logic              usb_rd;
  logic              usb_oe;
  logic              tx_fifo_prog_empty;
  logic              tx_fifo_empty;
  logic [DATA_W-1:0] tx_fifo_data;
  logic              tx_fifo_read;
  logic              rx_fifo_prog_full;
  logic [DATA_W-1:0] rx_fifo_data;
  logic [BE_W-1:0]   rx_fifo_be;
  logic              rx_fifo_write;

  modport master (
    input  usb_rxf, usb_txe, tx_fifo_prog_empty, tx_fifo_empty, tx_fifo_data, rx_fifo_prog_full,
    output usb_wr, usb_rd, usb_oe, tx_fifo_read, rx_fifo_data, rx_fifo_be, rx_fifo_write
  );

  modport slave (
    output usb_rxf, usb_txe, tx_fifo_prog_empty, tx_fifo_empty, tx_fifo_data, rx_fifo_prog_full,
    input  usb_wr, usb_rd, usb_oe, tx_fifo_read, rx_fifo_data, rx_fifo_be, rx_fifo_write
  );

endinterface

// File: rtl/ft60x_fifo_bridge_flush_timer.sv
// Counts consecutive cycles of cond; expired holds once TIMEOUT is reached until clr or cond drops.
module ft60x_fifo_bridge_flush_timer
  import ft60x_fifo_bridge_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic usb_clk,
  input  logic rst,
  input  logic cond,
  input  logic clr,
  output logic expired
);

  localparam int             CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Saturating timer; restarts whenever the qualifying condition breaks
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr || !cond) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_r != LIMIT) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/ft60x_fifo_bridge.sv
// FT600/FT601 245-synchronous FIFO bridge between the USB chip bus and the master TX/RX FIFOs.
// Build option FT_TX_FLUSH_EN: send a partial TX packet after FLUSH_TIMEOUT cycles below threshold.
module ft60x_fifo_bridge
  import ft60x_fifo_bridge_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int PACKET_SIZE   = 1024,
  parameter int RX_MAX_BURST  = 1024,
  parameter int FLUSH_TIMEOUT = 4096
) (
  input  logic                        usb_clk,
  input  logic                        rst,
  ft60x_fifo_bridge_if.master         bus,
  inout  wire  [DATA_W-1:0]           usb_data,
  inout  wire  [be_width(DATA_W)-1:0] usb_be
);

  localparam int                  BE_W     = be_width(DATA_W);
  localparam int                  RD_CNT_W = cnt_width(RX_MAX_BURST);
  localparam int                  WR_CNT_W = cnt_width(PACKET_SIZE);
  localparam logic [RD_CNT_W-1:0] RD_MAX   = RD_CNT_W'(RX_MAX_BURST);
  localparam logic [WR_CNT_W-1:0] WR_MAX   = WR_CNT_W'(PACKET_SIZE);
  localparam logic [RD_CNT_W-1:0] RD_ONE   = RD_CNT_W'(1);
  localparam logic [WR_CNT_W-1:0] WR_ONE   = WR_CNT_W'(1);

  state_e              state_r;
  state_e              state_s;
  dir_e                last_dir_r;
  dir_e                last_dir_s;
  logic                oe_r;
  logic                rd_r;
  logic                wr_r;
  logic [RD_CNT_W-1:0] rd_cnt_r;
  logic [RD_CNT_W-1:0] rd_cnt_inc_s;
  logic [WR_CNT_W-1:0] wr_cnt_r;
  logic [WR_CNT_W-1:0] wr_cnt_inc_s;
  logic [DATA_W-1:0]   rx_data_r;
  logic [BE_W-1:0]     rx_be_r;
  logic                rx_write_r;

  logic rx_ok_s;
  logic tx_ok_s;
  logic rd_take_s;
  logic usb_wr_s;
  logic wr_pop_s;
  logic drive_s;
  logic wr_entry_s;
  logic flush_expired_s;

`ifdef FT_TX_FLUSH_EN
  ft60x_fifo_bridge_flush_timer #(
    .TIMEOUT (FLUSH_TIMEOUT)
  ) u_flush_timer (
    .usb_clk (usb_clk),
    .rst     (rst),
    .cond    (!bus.tx_fifo_empty && bus.tx_fifo_prog_empty),
    .clr     (wr_entry_s),
    .expired (flush_expired_s)
  );
`else
  assign flush_expired_s = 1'b0;
`endif

  assign rx_ok_s    = bus.usb_rxf & ~bus.rx_fifo_prog_full;
  assign tx_ok_s    = bus.usb_txe & (~bus.tx_fifo_prog_empty | flush_expired_s);
  assign rd_take_s  = rd_r & bus.usb_rxf;
  assign usb_wr_s   = wr_r & ~bus.tx_fifo_empty;
  assign wr_pop_s   = usb_wr_s & bus.usb_txe;
  assign drive_s    = (state_r == ST_WR);
  assign wr_entry_s = (state_r != ST_WR) && (state_s == ST_WR);

  // Burst counters advance per transferred word and hold at their limit
  always_comb begin
    rd_cnt_inc_s = rd_cnt_r;
    wr_cnt_inc_s = wr_cnt_r;
    if (rd_take_s && (rd_cnt_r != RD_MAX)) begin
      rd_cnt_inc_s = rd_cnt_r + RD_ONE;
    end else begin
      rd_cnt_inc_s = rd_cnt_r;
    end
    if (wr_pop_s && (wr_cnt_r != WR_MAX)) begin
      wr_cnt_inc_s = wr_cnt_r + WR_ONE;
    end else begin
      wr_cnt_inc_s = wr_cnt_r;
    end
  end

  // Next-state: exits look at the post-increment count because strobes are registered
  always_comb begin
    state_s    = state_r;
    last_dir_s = last_dir_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_ok_s && tx_ok_s) begin
          if (last_dir_r == DIR_WR) begin
            state_s = ST_RD_OE;
          end else begin
            state_s = ST_WR;
          end
        end else if (rx_ok_s) begin
          state_s = ST_RD_OE;
        end else if (tx_ok_s) begin
          state_s = ST_WR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_OE: begin
        state_s = ST_RD;
      end
      ST_RD: begin
        if (!bus.usb_rxf || bus.rx_fifo_prog_full || (rd_cnt_inc_s == RD_MAX)) begin
          state_s    = ST_TURN;
          last_dir_s = DIR_RD;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_WR: begin
        if ((wr_cnt_inc_s == WR_MAX) || !bus.usb_txe || bus.tx_fifo_empty) begin
          state_s    = ST_TURN;
          last_dir_s = DIR_WR;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_TURN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, strobe flops and counters
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      last_dir_r <= DIR_WR;
      oe_r       <= 1'b0;
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      rd_cnt_r   <= {RD_CNT_W{1'b0}};
      wr_cnt_r   <= {WR_CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      last_dir_r <= last_dir_s;
      oe_r       <= (state_s == ST_RD_OE) || (state_s == ST_RD);
      rd_r       <= (state_s == ST_RD);
      wr_r       <= (state_s == ST_WR);
      rd_cnt_r   <= (state_s == ST_RD_OE) ? {RD_CNT_W{1'b0}} : rd_cnt_inc_s;
      wr_cnt_r   <= wr_entry_s ? {WR_CNT_W{1'b0}} : wr_cnt_inc_s;
    end
  end

  // RX capture: one registered push per word accepted on the bus
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      rx_data_r  <= {DATA_W{1'b0}};
      rx_be_r    <= {BE_W{1'b0}};
      rx_write_r <= 1'b0;
    end else begin
      rx_write_r <= rd_take_s;
      if (rd_take_s) begin
        rx_data_r <= usb_data;
        rx_be_r   <= usb_be;
      end else begin
        rx_data_r <= rx_data_r;
        rx_be_r   <= rx_be_r;
      end
    end
  end

  assign usb_data = drive_s ? bus.tx_fifo_data : {DATA_W{1'bz}};
  assign usb_be   = drive_s ? {BE_W{1'b1}}     : {BE_W{1'bz}};

  assign bus.usb_oe        = oe_r;
  assign bus.usb_rd        = rd_r;
  assign bus.usb_wr        = usb_wr_s;
  assign bus.tx_fifo_read  = wr_pop_s;
  assign bus.rx_fifo_data  = rx_data_r;
  assign bus.rx_fifo_be    = rx_be_r;
  assign bus.rx_fifo_write = rx_write_r;

endmodule

// File: tb/tb_ft60x_fifo_bridge.sv
// Directed bench for ft60x_fifo_bridge with an FT60x chip model, TX FIFO model and RX scoreboard.
module tb_ft60x_fifo_bridge;
  import ft60x_fifo_bridge_pkg::*;

  localparam int DATA_W    = 32;
  localparam int PE_THRESH = 4;

  logic        usb_clk = 1'b0;
  logic        rst     = 1'b1;
  wire  [31:0] usb_data;
  wire  [3:0]  usb_be;

  ft60x_fifo_bridge_if #(.DATA_W(DATA_W)) bus ();

  ft60x_fifo_bridge #(
    .DATA_W        (DATA_W),
    .PACKET_SIZE   (1024),
    .RX_MAX_BURST  (1024),
    .FLUSH_TIMEOUT (4096)
  ) u_dut (
    .usb_clk  (usb_clk),
    .rst      (rst),
    .bus      (bus.master),
    .usb_data (usb_data),
    .usb_be   (usb_be)
  );

  always #5 usb_clk = ~usb_clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          chip_rem = 0;
  int          chip_idx = 0;
  logic [31:0] chip_data = 32'h0;
  logic [3:0]  chip_be = 4'h0;
  logic [35:0] sb[$];
  logic [31:0] txq[$];
  int          tx_word_id = 0;
  int          tx_sent = 0;
  int          rx_pushed = 0;
  logic        txe_en = 1'b0;
  logic        pf = 1'b0;
  int          pf_after = 0;
  int          rd_run = 0;
  int          wr_run = 0;
  int          rd_runs[$];
  int          wr_runs[$];
  int          dir_log[$];
  int          turn_cnt = 0;
  int          last_oe_rise = 0;
  int          last_rd_rise = 0;
  logic        prev_oe = 1'b0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  state_e      prev_state = ST_IDLE;

  // Chip drives the bus whenever the bridge enables its outputs
  assign usb_data = bus.usb_oe ? chip_data : 32'hzzzz_zzzz;
  assign usb_be   = bus.usb_oe ? chip_be   : 4'bzzzz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_inputs();
    if (pf_after > 0 && rx_pushed >= pf_after) pf = 1'b1;
    bus.usb_rxf            = (chip_rem > 0);
    chip_data              = 32'hA500_0000 + chip_idx;
    chip_be                = 4'b0001 | chip_idx[3:0];
    bus.rx_fifo_prog_full  = pf;
    bus.usb_txe            = txe_en;
    bus.tx_fifo_empty      = (txq.size() == 0);
    bus.tx_fifo_data       = (txq.size() > 0) ? txq[0] : 32'h0;
    bus.tx_fifo_prog_empty = (txq.size() < PE_THRESH);
  endtask

  task automatic queue_tx(input int n);
    for (int i = 0; i < n; i++) begin
      txq.push_back(32'hC000_0000 + tx_word_id);
      tx_word_id++;
    end
    update_inputs();
  endtask

  // One clock: observe at the falling edge, advance the models just after the rising edge
  task automatic step();
    logic take;
    logic pop;
    logic [35:0] exp_w;
    @(negedge usb_clk);
    if (bus.rx_fifo_write === 1'b1) begin
      rx_pushed++;
      chk("rx_push_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        chk("rx_word", {bus.rx_fifo_be, bus.rx_fifo_data}, exp_w);
      end
    end
    if (bus.usb_wr === 1'b1 && txq.size() > 0)
      chk("wr_word", {usb_be, usb_data}, {4'hF, txq[0]});
    chk("bus_contention", 64'(u_dut.drive_s & bus.usb_oe), 64'd0);
    if (u_dut.state_r == ST_IDLE || u_dut.state_r == ST_TURN)
      chk("strobe_idle", {bus.usb_oe, bus.usb_rd, bus.usb_wr, bus.tx_fifo_read}, 64'd0);
    if (prev_state == ST_TURN)
      chk("turn_one_cycle", 64'(u_dut.state_r), 64'(ST_IDLE));
    if (u_dut.state_r == ST_TURN) turn_cnt++;
    take = bus.usb_rd & bus.usb_rxf;
    pop  = bus.tx_fifo_read;
    if (take) rd_run++;
    else if (rd_run > 0) begin rd_runs.push_back(rd_run); rd_run = 0; end
    if (pop) wr_run++;
    else if (wr_run > 0) begin wr_runs.push_back(wr_run); wr_run = 0; end
    if (bus.usb_oe && !prev_oe) begin dir_log.push_back(0); last_oe_rise = cyc; end
    if (bus.usb_rd && !prev_rd) last_rd_rise = cyc;
    if (bus.usb_wr && !prev_wr) dir_log.push_back(1);
    prev_oe    = bus.usb_oe;
    prev_rd    = bus.usb_rd;
    prev_wr    = bus.usb_wr;
    prev_state = u_dut.state_r;
    @(posedge usb_clk);
    #1;
    if (take) begin
      sb.push_back({chip_be, chip_data});
      chip_idx++;
      chip_rem--;
    end
    if (pop) begin
      void'(txq.pop_front());
      tx_sent++;
    end
    update_inputs();
    cyc++;
  endtask

  task automatic clear_logs();
    rd_runs.delete();
    wr_runs.delete();
    dir_log.delete();
    turn_cnt  = 0;
    rx_pushed = 0;
    tx_sent   = 0;
  endtask

  initial begin
    update_inputs();
    repeat (2) @(negedge usb_clk);
    chk("rst_state", 64'(u_dut.state_r), 64'(ST_IDLE));
    chk("rst_strobes", {bus.usb_oe, bus.usb_rd, bus.usb_wr, bus.tx_fifo_read, bus.rx_fifo_write}, 64'd0);
    chk("rst_rx_regs", {bus.rx_fifo_be, bus.rx_fifo_data}, 64'd0);
    chk("rst_bus_released", 64'(u_dut.drive_s), 64'd0);
    rst = 1'b0;

    // 1: eight-word read burst
    clear_logs();
    chip_rem = 8;
    update_inputs();
    for (int i = 0; i < 40; i++) step();
    chk("t1_oe_before_rd", 64'(last_rd_rise - last_oe_rise), 64'd1);
    chk("t1_pushes", 64'(rx_pushed), 64'd8);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    chk("t1_run_len", 64'(rd_runs.size() > 0 ? rd_runs[0] : 0), 64'd8);

    // 2: 1500 queued words split at the packet limit
    clear_logs();
    txe_en = 1'b1;
    queue_tx(1500);
    for (int i = 0; i < 1600; i++) step();
    chk("t2_bursts", 64'(wr_runs.size()), 64'd2);
    chk("t2_burst0", 64'(wr_runs.size() > 0 ? wr_runs[0] : 0), 64'd1024);
    chk("t2_burst1", 64'(wr_runs.size() > 1 ? wr_runs[1] : 0), 64'd476);
    chk("t2_turns", 64'(turn_cnt), 64'd2);
    chk("t2_sent", 64'(tx_sent), 64'd1500);

    // 3: both directions eligible, fair alternation starting with RX
    clear_logs();
    chip_rem = 1100;
    queue_tx(1100);
    for (int i = 0; i < 2300; i++) step();
    chk("t3_burst_count", 64'(dir_log.size()), 64'd4);
    chk("t3_dir0_rd", 64'(dir_log.size() > 0 ? dir_log[0] : 9), 64'd0);
    chk("t3_dir1_wr", 64'(dir_log.size() > 1 ? dir_log[1] : 9), 64'd1);
    chk("t3_dir2_rd", 64'(dir_log.size() > 2 ? dir_log[2] : 9), 64'd0);
    chk("t3_rd_burst0", 64'(rd_runs.size() > 0 ? rd_runs[0] : 0), 64'd1024);
    chk("t3_wr_burst0", 64'(wr_runs.size() > 0 ? wr_runs[0] : 0), 64'd1024);
    chk("t3_turns", 64'(turn_cnt), 64'd4);
    chk("t3_rx_pushed", 64'(rx_pushed), 64'd1100);
    chk("t3_tx_sent", 64'(tx_sent), 64'd1100);

    // 4: RX FIFO nearly full after the fifth push
    clear_logs();
    chip_rem = 20;
    pf_after = 5;
    update_inputs();
    for (int i = 0; i < 30; i++) step();
    chk("t4_push_le7", 64'(rx_pushed <= 7), 64'd1);
    chk("t4_push_ge5", 64'(rx_pushed >= 5), 64'd1);
    chk("t4_no_lost", 64'(sb.size()), 64'd0);
    chk("t4_parked", 64'(u_dut.state_r), 64'(ST_IDLE));
    pf_after = 0;
    pf = 1'b0;
    update_inputs();
    for (int i = 0; i < 40; i++) step();
    chk("t4_total", 64'(rx_pushed), 64'd20);
    chk("t4_chip_drained", 64'(chip_rem), 64'd0);

    // 5: asynchronous reset in the middle of a write burst
    clear_logs();
    queue_tx(600);
    for (int i = 0; i < 700; i++) begin
      step();
      if (tx_sent >= 300) break;
    end
    chk("t5_reached_300", 64'(tx_sent), 64'd300);
    chk("t5_mid_wr", 64'(bus.usb_wr), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_strobes", {bus.usb_wr, bus.tx_fifo_read, bus.usb_oe, bus.usb_rd}, 64'd0);
    chk("t5_rst_bus_z", 64'(u_dut.drive_s), 64'd0);
    txq.delete();
    update_inputs();
    @(negedge usb_clk);
    rst = 1'b0;
    #1;
    chk("t5_idle_after", 64'(u_dut.state_r), 64'(ST_IDLE));
    wr_run = 0;
    for (int i = 0; i < 5; i++) step();
    chk("t5_quiet", 64'(tx_sent), 64'd300);

    // 6: three residual words below the threshold
    clear_logs();
    queue_tx(3);
    for (int i = 0; i < 4000; i++) step();
    chk("t6_held", 64'(tx_sent), 64'd0);
    for (int i = 0; i < 300; i++) step();
`ifdef FT_TX_FLUSH_EN
    chk("t6_flushed", 64'(tx_sent), 64'd3);
`else
    chk("t6_flushed", 64'(tx_sent), 64'd0);
`endif
    chk("t6_idle", 64'(u_dut.state_r), 64'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
